// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
//   Single-outstanding AXI4-Lite master. It bridges a simple user request port
//   onto the AW/W/B and AR/R channels. One write or one read is in flight at a
//   time. Completion is signalled by a one-cycle pulse on 'ready'.
//
// Parameters
//   ADDR_WIDTH  address width (AWADDR/ARADDR/aw_addr/ar_addr)
//   DATA_WIDTH  data width (WDATA/RDATA/w_data/r_data); strobes DATA_WIDTH/8
//
// Ports
//   ACLK, ARESET                clock; asynchronous active-high reset
//   AW*: AWVALID/AWADDR out, AWREADY in       write address channel
//   W* : WVALID/WDATA/WSTRB out, WREADY in    write data channel
//   B* : BREADY out, BVALID/BRESP in          write response channel
//   AR*: ARVALID/ARADDR out, ARREADY in       read address channel
//   R* : RREADY out, RVALID/RDATA in          read data channel
//   valid / valid_r             user write / read request (sampled in IDLE)
//   aw_addr, w_data, w_strb     user write address, data, strobes
//   ar_addr                     user read address
//   r_data                      last captured read data
//   ready                       one-cycle completion pulse
//   resp_err                    (AXI_MASTER_RESP_ERR_EN only) pulses with
//                               ready when the captured BRESP is not OKAY
//
// Optional feature macro: AXI_MASTER_RESP_ERR_EN
// -----------------------------------------------------------------------------
module axi_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      AWREADY,
    output logic                      AWVALID,
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic                      WREADY,
    output logic                      WVALID,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,
    input  logic                      ARREADY,
    output logic                      ARVALID,
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic                      valid_r,
    input  logic                      valid,
    input  logic [ADDR_WIDTH-1:0]     ar_addr,
    input  logic [ADDR_WIDTH-1:0]     aw_addr,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic [DATA_WIDTH/8-1:0]   w_strb,
    output logic [DATA_WIDTH-1:0]     r_data,
    output logic                      ready
`ifdef AXI_MASTER_RESP_ERR_EN
    ,
    output logic                      resp_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q,  wvalid_d;
    logic                    bready_q,  bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q,  rready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q,   wstrb_d;
    logic [ADDR_WIDTH-1:0]   araddr_q,  araddr_d;
    logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;

    // A channel is still pending next cycle unless its handshake fires now.
    // Once a VALID has dropped the channel counts as done.
    logic aw_pending, w_pending;
    assign aw_pending = awvalid_q & ~AWREADY;
    assign w_pending  = wvalid_q  & ~WREADY;

`ifdef AXI_MASTER_RESP_ERR_EN
    logic [1:0] bresp_q, bresp_d;
`else
    logic bresp_unused;
    assign bresp_unused = ^BRESP;
`endif

    // State register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                // A write takes priority; a simultaneous read is dropped.
                if (valid) begin
                    state_d = S_WR_ADDR_DATA;
                end else if (valid_r) begin
                    state_d = S_RD_ADDR;
                end
            end
            S_WR_ADDR_DATA: if (!aw_pending && !w_pending) state_d = S_WR_RESP;
            S_WR_RESP:      if (BVALID && bready_q)        state_d = S_DONE;
            S_RD_ADDR:      if (ARREADY && arvalid_q)      state_d = S_RD_DATA;
            S_RD_DATA:      if (RVALID && rready_q)        state_d = S_DONE;
            S_DONE:         state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered channel signals, plus the
    // Moore completion pulse. Every VALID/READY is registered so none of them
    // depends combinationally on the slave's handshake inputs.
    always_comb begin
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
`ifdef AXI_MASTER_RESP_ERR_EN
        bresp_d   = bresp_q;
`endif
        unique case (state_q)
            S_IDLE: begin
`ifdef AXI_MASTER_RESP_ERR_EN
                // Clear any stale response so a read never flags an error.
                if (valid || valid_r) bresp_d = 2'b00;
`endif
                if (valid) begin
                    awaddr_d  = aw_addr;
                    wdata_d   = w_data;
                    wstrb_d   = w_strb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else if (valid_r) begin
                    araddr_d  = ar_addr;
                    arvalid_d = 1'b1;
                end
            end
            S_WR_ADDR_DATA: begin
                awvalid_d = aw_pending;
                wvalid_d  = w_pending;
                if (!aw_pending && !w_pending) bready_d = 1'b1;
            end
            S_WR_RESP: begin
                if (BVALID && bready_q) begin
                    bready_d = 1'b0;
`ifdef AXI_MASTER_RESP_ERR_EN
                    bresp_d  = BRESP;
`endif
                end
            end
            S_RD_ADDR: begin
                if (ARREADY && arvalid_q) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (RVALID && rready_q) begin
                    rdata_d  = RDATA;
                    rready_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign ready = (state_q == S_DONE);

`ifdef AXI_MASTER_RESP_ERR_EN
    assign resp_err = (state_q == S_DONE) && (bresp_q != 2'b00);
`endif

    // Channel and datapath registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
            rdata_q   <= '0;
`ifdef AXI_MASTER_RESP_ERR_EN
            bresp_q   <= 2'b00;
`endif
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
`ifdef AXI_MASTER_RESP_ERR_EN
            bresp_q   <= bresp_d;
`endif
        end
    end

    assign AWVALID = awvalid_q;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;
    assign AWADDR  = awaddr_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign ARADDR  = araddr_q;
    assign r_data  = rdata_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master
//   Bench for axi_lite_master against a behavioural byte-addressed AXI-Lite
//   slave with programmable ready/response delays. A byte-array reference
//   model tracks the expected memory image and read results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_lite_master;

    localparam int MEM_BYTES = 64;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        AWREADY, AWVALID;
    logic [31:0] AWADDR;
    logic        WREADY, WVALID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;
    logic        ARREADY, ARVALID;
    logic [31:0] ARADDR;
    logic [31:0] RDATA;
    logic        RVALID, RREADY;
    logic        valid_r, valid;
    logic [31:0] ar_addr, aw_addr, w_data;
    logic [3:0]  w_strb;
    logic [31:0] r_data;
    logic        ready;
    logic        resp_err;

    always #5 ACLK = ~ACLK;

    axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWREADY(AWREADY), .AWVALID(AWVALID), .AWADDR(AWADDR),
        .WREADY(WREADY), .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARREADY(ARREADY), .ARVALID(ARVALID), .ARADDR(ARADDR),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .valid_r(valid_r), .valid(valid),
        .ar_addr(ar_addr), .aw_addr(aw_addr), .w_data(w_data), .w_strb(w_strb),
        .r_data(r_data), .ready(ready)
`ifdef AXI_MASTER_RESP_ERR_EN
        , .resp_err(resp_err)
`endif
    );

`ifndef AXI_MASTER_RESP_ERR_EN
    assign resp_err = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural slave ----------------
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [7:0]  s_mem [MEM_BYTES];
    bit          mem_ready = 0;
    bit          aw_got, w_got, ar_got;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    int          n_ar_hs = 0;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;

    always @(posedge ACLK) begin
        aw_hs <= !ARESET && AWVALID && AWREADY;
        w_hs  <= !ARESET && WVALID  && WREADY;
        b_hs  <= !ARESET && BVALID  && BREADY;
        ar_hs <= !ARESET && ARVALID && ARREADY;
        r_hs  <= !ARESET && RVALID  && RREADY;
    end

    always @(negedge ACLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < MEM_BYTES; i++) s_mem[i] = 8'(i * 7 + 49);
            mem_ready = 1;
        end
        if (ARESET) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
            ARREADY = 0; RVALID = 0; RDATA = $urandom;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (aw_hs) begin
                AWREADY = 0; aw_got = 1;
            end else if (AWVALID && !AWREADY && !aw_got) begin
                if (aw_cnt >= aw_delay) begin AWREADY = 1; s_awaddr = AWADDR; aw_cnt = 0; end
                else aw_cnt++;
            end
            if (w_hs) begin
                WREADY = 0; w_got = 1;
            end else if (WVALID && !WREADY && !w_got) begin
                if (w_cnt >= w_delay) begin WREADY = 1; s_wdata = WDATA; s_wstrb = WSTRB; w_cnt = 0; end
                else w_cnt++;
            end
            if (b_hs) begin
                BVALID = 0; BRESP = 0; aw_got = 0; w_got = 0;
            end else if (aw_got && w_got && !BVALID) begin
                if (b_cnt >= b_delay) begin
                    for (int i = 0; i < 4; i++)
                        if (s_wstrb[i]) s_mem[(int'(s_awaddr[5:0]) + i) % MEM_BYTES] = s_wdata[8*i +: 8];
                    BVALID = 1; BRESP = bresp_cfg; b_cnt = 0;
                end else b_cnt++;
            end
            if (ar_hs) begin
                ARREADY = 0; ar_got = 1; n_ar_hs++;
            end else if (ARVALID && !ARREADY && !ar_got) begin
                if (ar_cnt >= ar_delay) begin ARREADY = 1; s_araddr = ARADDR; ar_cnt = 0; end
                else ar_cnt++;
            end
            if (r_hs) begin
                RVALID = 0; ar_got = 0; RDATA = $urandom;
            end else if (ar_got && !RVALID) begin
                if (r_cnt >= r_delay) begin
                    for (int i = 0; i < 4; i++)
                        RDATA[8*i +: 8] = s_mem[(int'(s_araddr[5:0]) + i) % MEM_BYTES];
                    RVALID = 1; r_cnt = 0;
                end else r_cnt++;
            end
        end
    end

    // ---------------- protocol monitor ----------------
    // Counts violations: VALID dropping or payload changing before handshake,
    // and BREADY raised while AW or W is still outstanding.
    int          proto_err = 0;
    bit          pend_aw, pend_w, pend_ar;
    logic [31:0] hold_awaddr, hold_wdata, hold_araddr;
    logic [3:0]  hold_wstrb;

    always @(posedge ACLK) begin
        if (ARESET) begin
            pend_aw = 0; pend_w = 0; pend_ar = 0;
        end else begin
            if (pend_aw && (!AWVALID || AWADDR !== hold_awaddr)) proto_err++;
            if (pend_w && (!WVALID || WDATA !== hold_wdata || WSTRB !== hold_wstrb)) proto_err++;
            if (pend_ar && (!ARVALID || ARADDR !== hold_araddr)) proto_err++;
            if (BREADY && (AWVALID || WVALID)) proto_err++;
            pend_aw = AWVALID && !AWREADY; hold_awaddr = AWADDR;
            pend_w  = WVALID && !WREADY;   hold_wdata = WDATA; hold_wstrb = WSTRB;
            pend_ar = ARVALID && !ARREADY; hold_araddr = ARADDR;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [MEM_BYTES];

    function automatic void ref_write(input int a, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (s[i]) ref_mem[a + i] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] ref_read(input int a);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_mem[a + i];
        return r;
    endfunction

    function automatic int mem_mismatches();
        int m = 0;
        for (int i = 0; i < MEM_BYTES; i++)
            if (s_mem[i] !== ref_mem[i]) m++;
        return m;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the user inputs after the sample edge, then
    // watch for the completion pulse within a bounded window.
    task automatic do_txn(input bit wr, input bit rd, input int a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output int pulses,
                          output bit split, output bit err);
        @(negedge ACLK);
        valid = wr; valid_r = rd;
        aw_addr = 32'(a); ar_addr = 32'(a); w_data = d; w_strb = s;
        @(negedge ACLK);
        valid = 0; valid_r = 0;
        aw_addr = $urandom; ar_addr = $urandom; w_data = $urandom; w_strb = 4'($urandom);
        lat = 0; pulses = 0; split = 0; err = 0;
        for (int c = 1; c <= 200; c++) begin
            if (ready) begin
                pulses++;
                if (lat == 0) lat = c;
                if (resp_err) err = 1;
            end
            if (AWVALID && !WVALID) split = 1;
            if (lat != 0 && c > lat + 3) break;
            @(negedge ACLK);
        end
        $display("txn wr=%0b rd=%0b addr=%0h data=%08h strb=%0h lat=%0d pulses=%0d r_data=%08h",
                 wr, rd, a, d, s, lat, pulses, r_data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int          lat, pulses, n_ar_before, a;
        bit          split, err, is_wr;
        logic [31:0] exp_rdata, d;
        logic [3:0]  s;

        ARESET = 1; valid = 0; valid_r = 0;
        aw_addr = 0; ar_addr = 0; w_data = 0; w_strb = 0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i * 7 + 49);
        exp_rdata = 32'h0;

        repeat (3) @(negedge ACLK);
        check("reset_ctrl", 160'({AWVALID, WVALID, BREADY, ARVALID, RREADY, ready, resp_err}), 160'(0));
        check("reset_data", {AWADDR, WDATA, WSTRB, ARADDR, r_data}, 160'(0));
        #2 ARESET = 0;

        // 1: single-lane write at 0, all-ready slave
        do_txn(1, 0, 0, 32'h12345678, 4'b0001, lat, pulses, split, err);
        ref_write(0, 32'h12345678, 4'b0001);
        check_i("t1_pulses", pulses, 1);
        check_i("t1_latency_le4", int'(lat >= 1 && lat <= 4), 1);
        check("t1_mem0", 160'(s_mem[0]), 160'(8'h78));
        check_i("t1_mem", mem_mismatches(), 0);

        // 2: two lanes at 1
        do_txn(1, 0, 1, 32'h12345678, 4'b0011, lat, pulses, split, err);
        ref_write(1, 32'h12345678, 4'b0011);
        check_i("t2_pulses", pulses, 1);
        check("t2_mem12", 160'({s_mem[2], s_mem[1]}), 160'(16'h5678));
        check_i("t2_mem", mem_mismatches(), 0);

        // 3: sparse strobes at 3, lane 1 untouched
        do_txn(1, 0, 3, 32'h12345678, 4'b1101, lat, pulses, split, err);
        check("t3_lanes", 160'({s_mem[6], s_mem[5], s_mem[3]}), 160'(24'h123478));
        check("t3_lane1", 160'(s_mem[4]), 160'(ref_mem[4]));
        ref_write(3, 32'h12345678, 4'b1101);
        check_i("t3_mem", mem_mismatches(), 0);

        // 4: full write at 7 then read back
        do_txn(1, 0, 7, 32'h12345678, 4'b1111, lat, pulses, split, err);
        ref_write(7, 32'h12345678, 4'b1111);
        check_i("t4_wr_pulses", pulses, 1);
        check("t4_r_data_held", 160'(r_data), 160'(exp_rdata));
        do_txn(0, 1, 7, 32'h0, 4'h0, lat, pulses, split, err);
        exp_rdata = ref_read(7);
        check_i("t4_rd_pulses", pulses, 1);
        check_i("t4_rd_latency_le4", int'(lat >= 1 && lat <= 4), 1);
        check("t4_r_data", 160'(r_data), 160'(32'h12345678));

        // 5: AWREADY held low three cycles while W is accepted at once
        aw_delay = 3; w_delay = 0;
        do_txn(1, 0, 20, 32'hCAFEF00D, 4'b1111, lat, pulses, split, err);
        ref_write(20, 32'hCAFEF00D, 4'b1111);
        check_i("t5_w_before_aw", int'(split), 1);
        check_i("t5_pulses", pulses, 1);
        check_i("t5_protocol", proto_err, 0);
        check_i("t5_mem", mem_mismatches(), 0);
        aw_delay = 0;

        // write and read requested together: write wins, read dropped
        n_ar_before = n_ar_hs;
        do_txn(1, 1, 24, 32'hA5A55A5A, 4'b1111, lat, pulses, split, err);
        ref_write(24, 32'hA5A55A5A, 4'b1111);
        check_i("both_no_read", n_ar_hs - n_ar_before, 0);
        check_i("both_pulses", pulses, 1);
        check_i("both_mem", mem_mismatches(), 0);
        check("both_r_data_held", 160'(r_data), 160'(exp_rdata));

        // random mix with random slave timing and responses
        for (int k = 0; k < 24; k++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3); bresp_cfg = 2'($urandom_range(0, 3));
            a = $urandom_range(0, MEM_BYTES - 4);
            d = $urandom; s = 4'($urandom_range(0, 15));
            is_wr = bit'($urandom_range(0, 1));
            do_txn(is_wr, !is_wr, a, d, s, lat, pulses, split, err);
            check_i("rnd_pulses", pulses, 1);
            if (is_wr) begin
                ref_write(a, d, s);
                check_i("rnd_mem", mem_mismatches(), 0);
                check("rnd_r_data_held", 160'(r_data), 160'(exp_rdata));
`ifdef AXI_MASTER_RESP_ERR_EN
                check_i("rnd_resp_err_wr", int'(err), int'(bresp_cfg != 2'b00));
`endif
            end else begin
                exp_rdata = ref_read(a);
                check("rnd_r_data", 160'(r_data), 160'(exp_rdata));
`ifdef AXI_MASTER_RESP_ERR_EN
                check_i("rnd_resp_err_rd", int'(err), 0);
`endif
            end
        end
        aw_delay = 0; w_delay = 0; ar_delay = 0; r_delay = 0; bresp_cfg = 2'b00;

        // 6: reset while waiting for B; response is held back by the slave
        b_delay = 20;
        @(negedge ACLK);
        valid = 1; aw_addr = 32'd40; w_data = 32'hDEADBEEF; w_strb = 4'hF;
        @(negedge ACLK);
        valid = 0;
        for (int c = 0; c < 20 && !BREADY; c++) @(negedge ACLK);
        check_i("t6_in_wr_resp", int'(BREADY), 1);
        #2 ARESET = 1;
        #1;
        check("t6_reset_ctrl", 160'({AWVALID, WVALID, BREADY, ARVALID, RREADY, ready, resp_err}), 160'(0));
        check("t6_reset_data", {AWADDR, WDATA, WSTRB, ARADDR, r_data}, 160'(0));
        exp_rdata = 32'h0;
        @(negedge ACLK);
        #2 ARESET = 0;
        b_delay = 0;
        pulses = 0;
        repeat (6) begin
            @(negedge ACLK);
            if (ready) pulses++;
        end
        check_i("t6_no_ready", pulses, 0);
        check_i("t6_mem_untouched", mem_mismatches(), 0);
        do_txn(1, 0, 40, 32'h0BADF00D, 4'b1111, lat, pulses, split, err);
        ref_write(40, 32'h0BADF00D, 4'b1111);
        check_i("t6_after_pulses", pulses, 1);
        check_i("t6_after_mem", mem_mismatches(), 0);
        do_txn(0, 1, 40, 32'h0, 4'h0, lat, pulses, split, err);
        exp_rdata = ref_read(40);
        check("t6_after_read", 160'(r_data), 160'(exp_rdata));

        check_i("protocol_total", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
